// File: rtl/acq_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : acq_sequencer
// Description : Sequences one multi-period BRAM acquisition/averaging run.
//               After a start request it waits for a period boundary
//               (end_cycle). It then drives a write window of count_max+1
//               consecutive addresses, once per period, for n_avg periods.
//               The first period is flagged so the datapath overwrites
//               instead of accumulating.
// Ports       : clk, resetn      - clock, asynchronous active-low reset
//               start, stop      - single-cycle run request / abort
//               end_cycle        - period boundary strobe
//               count_max, n_avg - run configuration, latched on start
//               wen, addr, first - BRAM write strobe, address, overwrite flag
//               avg_count        - index of the current/last period
//               busy, done       - run in progress / run completed
//               overrun          - sticky: period boundary seen mid-window
// Revision    : 1.0 - initial release
// ============================================================================
module acq_sequencer #(
  parameter int BRAM_WIDTH = 13,
  parameter int NAVG_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  end_cycle,
  input  logic [BRAM_WIDTH-1:0] count_max,
  input  logic [NAVG_WIDTH-1:0] n_avg,
  output logic                  wen,
  output logic [BRAM_WIDTH-1:0] addr,
  output logic                  first,
  output logic [NAVG_WIDTH-1:0] avg_count,
  output logic                  busy,
  output logic                  done,
  output logic                  overrun
);

  localparam logic [NAVG_WIDTH-1:0] c_NAVG_ONE = NAVG_WIDTH'(1);
  localparam logic [BRAM_WIDTH-1:0] c_ADDR_ONE = BRAM_WIDTH'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARMED = 3'd1,
    S_ACQ   = 3'd2,
    S_GAP   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                  r_state;
  logic [BRAM_WIDTH-1:0]   r_cm_l;
  logic [NAVG_WIDTH-1:0]   r_n_l;
  logic                    r_wen;
  logic [BRAM_WIDTH-1:0]   r_addr;
  logic                    r_first;
  logic [NAVG_WIDTH-1:0]   r_avg_count;
  logic                    r_busy;
  logic                    r_done;
  logic                    r_overrun;

  logic                    w_at_end;
  logic                    w_last_period;

  // Last address of the window, and whether this window is the final period.
  assign w_at_end      = (r_addr == r_cm_l);
  assign w_last_period = (r_avg_count == (r_n_l - c_NAVG_ONE));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= S_IDLE;
      r_cm_l      <= '0;
      r_n_l       <= c_NAVG_ONE;
      r_wen       <= 1'b0;
      r_addr      <= '0;
      r_first     <= 1'b0;
      r_avg_count <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_overrun   <= 1'b0;
    end else if (stop) begin
      // Abort from any state; addr/avg_count keep their last values and
      // overrun stays sticky so the host can still read it.
      r_state <= S_IDLE;
      r_wen   <= 1'b0;
      r_first <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_cm_l      <= count_max;
            r_n_l       <= (n_avg == '0) ? c_NAVG_ONE : n_avg;
            r_avg_count <= '0;
            r_done      <= 1'b0;
            r_overrun   <= 1'b0;
            r_busy      <= 1'b1;
            r_state     <= S_ARMED;
          end
        end

        S_ARMED: begin
          if (end_cycle) begin
            r_state <= S_ACQ;
            r_wen   <= 1'b1;
            r_addr  <= '0;
            r_first <= (r_avg_count == '0);
          end
        end

        S_ACQ: begin
          // A boundary before the window is complete means the timing
          // source period is shorter than the window.
          if (end_cycle && !w_at_end) begin
            r_overrun <= 1'b1;
          end
          if (w_at_end) begin
            if (w_last_period) begin
              r_state <= S_DONE;
              r_wen   <= 1'b0;
              r_first <= 1'b0;
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
            end else begin
              r_avg_count <= r_avg_count + c_NAVG_ONE;
              r_first     <= 1'b0;
              if (end_cycle) begin
                // Boundary coincides with the last address: restart the
                // window immediately with no idle cycle.
                r_addr <= '0;
              end else begin
                r_state <= S_GAP;
                r_wen   <= 1'b0;
              end
            end
          end else begin
            r_addr <= r_addr + c_ADDR_ONE;
          end
        end

        S_GAP: begin
          if (end_cycle) begin
            r_state <= S_ACQ;
            r_wen   <= 1'b1;
            r_addr  <= '0;
            r_first <= (r_avg_count == '0);
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_wen   <= 1'b0;
          r_first <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign wen       = r_wen;
  assign addr      = r_addr;
  assign first     = r_first;
  assign avg_count = r_avg_count;
  assign busy      = r_busy;
  assign done      = r_done;
  assign overrun   = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_acq_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_acq_sequencer
// Description : Self-checking bench for acq_sequencer. Each scenario fills an
//               end_cycle schedule. The reference derives the period start
//               times from that schedule, then the expected value of every
//               output at every cycle from those start times.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_acq_sequencer;

  localparam int BW   = 13;
  localparam int NW   = 16;
  localparam int MAXL = 400;

  logic          clk = 1'b0;
  logic          resetn;
  logic          start;
  logic          stop;
  logic          end_cycle;
  logic [BW-1:0] count_max;
  logic [NW-1:0] n_avg;
  logic          wen;
  logic [BW-1:0] addr;
  logic          first;
  logic [NW-1:0] avg_count;
  logic          busy;
  logic          done;
  logic          overrun;

  int errors = 0;
  int checks = 0;
  int last_addr = 0;
  bit ec [MAXL];

  acq_sequencer #(.BRAM_WIDTH(BW), .NAVG_WIDTH(NW)) dut (
    .clk(clk), .resetn(resetn), .start(start), .stop(stop),
    .end_cycle(end_cycle), .count_max(count_max), .n_avg(n_avg),
    .wen(wen), .addr(addr), .first(first), .avg_count(avg_count),
    .busy(busy), .done(done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic idle_inputs;
    start = 1'b0; stop = 1'b0; end_cycle = 1'b0;
    count_max = '0; n_avg = '0;
  endtask

  task automatic clear_ec;
    for (int t = 0; t < MAXL; t++) ec[t] = 1'b0;
  endtask

  // Run one scenario. Output index c is the register state just after
  // clock edge c; start is applied at edge 0. A period starts at the first
  // boundary at or after its base cycle; the next base is one past the
  // previous period's last write. stop_at/sb of -2 are chosen randomly.
  task automatic run_case(input string name, input int cm, input int navg,
                          input int stop_at_in, input int sb_in);
    int nn, base, done_c, last_c, ev, e_addr, e_avg, stop_at, sb, lim;
    int s [16];
    bit found, stopped, e_wen, e_first, e_done, e_busy, e_over;
    nn   = (navg == 0) ? 1 : navg;
    base = 1;
    found = 1'b1;
    for (int k = 0; k < nn; k++) begin
      s[k] = -1;
      if (found) begin
        found = 1'b0;
        for (int t = base; t < MAXL; t++) begin
          if (ec[t]) begin s[k] = t; found = 1'b1; break; end
        end
        base = s[k] + cm + 1;
      end
    end
    done_c = (s[nn-1] >= 0) ? s[nn-1] + cm + 1 : MAXL;
    stop_at = stop_at_in;
    if (stop_at == -2)
      stop_at = ($urandom_range(0, 2) == 0) ?
                int'($urandom_range(1, (done_c < MAXL-8) ? done_c : MAXL-8)) : -1;
    sb = sb_in;
    if (sb == -2) begin
      lim = (stop_at >= 0 && stop_at < done_c) ? stop_at : done_c;
      sb  = (lim > 1) ? int'($urandom_range(1, lim - 1)) : -1;
    end
    last_c = (stop_at >= 0) ? stop_at + 3 : done_c + 3;
    if (last_c > MAXL - 1) last_c = MAXL - 1;
    e_over = 1'b0;
    e_addr = last_addr;
    for (int c = 0; c <= last_c; c++) begin
      start     = (c == 0) || (c == sb);
      stop      = (c == stop_at);
      end_cycle = ec[c];
      count_max = (c == 0) ? BW'(cm)   : BW'($urandom);
      n_avg     = (c == 0) ? NW'(navg) : NW'($urandom);
      @(posedge clk); #1;
      stopped = (stop_at >= 0) && (c >= stop_at);
      ev      = stopped ? stop_at - 1 : c;
      e_wen = 1'b0; e_first = 1'b0; e_addr = last_addr; e_avg = 0;
      for (int k = 0; k < nn; k++) begin
        if (s[k] >= 0 && s[k] <= ev)
          e_addr = (ev - s[k] < cm) ? ev - s[k] : cm;
        if (!stopped && s[k] >= 0 && c >= s[k] && c <= s[k] + cm) begin
          e_wen = 1'b1; e_first = (k == 0);
        end
        if (k < nn - 1 && s[k] >= 0 && s[k] + cm + 1 <= ev) e_avg++;
        if (ec[c] && !stopped && s[k] >= 0 && c >= s[k] + 1 && c <= s[k] + cm)
          e_over = 1'b1;
      end
      e_done = !stopped && (c >= done_c);
      e_busy = !stopped && !e_done;

      checks++;
      if (wen !== e_wen) begin
        errors++; $display("FAIL %s wen c=%0d got=%b exp=%b", name, c, wen, e_wen);
      end
      checks++;
      if (addr !== BW'(e_addr)) begin
        errors++; $display("FAIL %s addr c=%0d got=%0d exp=%0d", name, c, addr, e_addr);
      end
      checks++;
      if (first !== e_first) begin
        errors++; $display("FAIL %s first c=%0d got=%b exp=%b", name, c, first, e_first);
      end
      checks++;
      if (avg_count !== NW'(e_avg)) begin
        errors++; $display("FAIL %s avg_count c=%0d got=%0d exp=%0d", name, c, avg_count, e_avg);
      end
      checks++;
      if (busy !== e_busy) begin
        errors++; $display("FAIL %s busy c=%0d got=%b exp=%b", name, c, busy, e_busy);
      end
      checks++;
      if (done !== e_done) begin
        errors++; $display("FAIL %s done c=%0d got=%b exp=%b", name, c, done, e_done);
      end
      checks++;
      if (overrun !== e_over) begin
        errors++; $display("FAIL %s overrun c=%0d got=%b exp=%b", name, c, overrun, e_over);
      end
    end
    last_addr = e_addr;
    idle_inputs();
  endtask

  task automatic test_reset;
    resetn = 1'b0;
    idle_inputs();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({wen, first, busy, done, overrun, addr, avg_count} !== '0) begin
      errors++;
      $display("FAIL reset_values got wen=%b first=%b busy=%b done=%b ovr=%b addr=%0d avg=%0d exp all 0",
               wen, first, busy, done, overrun, addr, avg_count);
    end
    @(negedge clk);
    resetn = 1'b1;
    last_addr = 0;
  endtask

  task automatic test_basic;
    clear_ec();
    for (int t = 0; t < MAXL; t++) ec[t] = (t % 10 == 5);
    run_case("basic", 3, 2, -1, -1);
  endtask

  task automatic test_back_to_back;
    clear_ec();
    for (int t = 2; t < 20; t++) ec[t] = ((t - 2) % 5 == 0);
    run_case("back_to_back", 4, 3, -1, -1);
  endtask

  task automatic test_overrun_stop;
    clear_ec();
    ec[2] = 1'b1; ec[6] = 1'b1; ec[30] = 1'b1;
    run_case("overrun_stop", 7, 3, 14, -1);
  endtask

  task automatic test_edge_config;
    clear_ec();
    ec[3] = 1'b1; ec[4] = 1'b1;
    run_case("edge_config", 0, 0, -1, 2);
  endtask

  task automatic test_reset_midburst;
    start = 1'b1; count_max = BW'(9); n_avg = NW'(2);
    @(posedge clk); #1;
    start = 1'b0; end_cycle = 1'b1;
    @(posedge clk); #1;
    end_cycle = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (wen !== 1'b1 || addr !== BW'(5)) begin
      errors++; $display("FAIL pre_reset_burst got wen=%b addr=%0d exp wen=1 addr=5", wen, addr);
    end
    #2 resetn = 1'b0;
    #1;
    checks++;
    if ({wen, first, busy, done, overrun, addr, avg_count} !== '0) begin
      errors++;
      $display("FAIL async_reset got wen=%b first=%b busy=%b done=%b ovr=%b addr=%0d avg=%0d exp all 0",
               wen, first, busy, done, overrun, addr, avg_count);
    end
    @(negedge clk);
    resetn = 1'b1;
    last_addr = 0;
    clear_ec();
    ec[2] = 1'b1; ec[12] = 1'b1;
    run_case("post_reset", 5, 2, -1, -1);
  endtask

  task automatic test_random;
    int cm, navg;
    for (int i = 0; i < 12; i++) begin
      cm   = int'($urandom_range(0, 15));
      navg = int'($urandom_range(0, 4));
      for (int t = 0; t < MAXL; t++) ec[t] = ($urandom_range(0, 4) == 0);
      run_case("random", cm, navg, -2, -2);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_overrun_stop();
    test_edge_config();
    test_reset_midburst();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
